// File: rtl/operand_pkg.sv
// Shared operand source-select codes and fixed buffer sizing.
package operand_pkg;

  localparam int unsigned BUF_DEPTH   = 2;
  localparam int unsigned SEL_COUNT_W = 16;

  typedef enum logic [1:0] {
    SRC_BANK  = 2'd0,
    SRC_R     = 2'd1,
    SRC_IMM_S = 2'd2,
    SRC_IMM_Z = 2'd3
  } src_sel_e;

endpackage : operand_pkg

// File: rtl/sign_extend.sv
// Widens a raw immediate to OUT_W bits by sign or zero extension.
module sign_extend #(
  parameter int unsigned IN_W  = 10,
  parameter int unsigned OUT_W = 16
) (
  input  logic [IN_W-1:0]  din,
  input  logic             zero_ext,
  output logic [OUT_W-1:0] dout
);

  logic fill;

  // Upper bits take either the immediate's top bit or zero.
  assign fill = zero_ext ? 1'b0 : din[IN_W-1];
  assign dout = {{(OUT_W-IN_W){fill}}, din};

endmodule : sign_extend

// File: rtl/operand_select.sv
// Selects an operand from bank/R/immediate sources and queues it in a
// two-entry FIFO toward the consumer, counting accepted requests.
module operand_select
  import operand_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned IMM_W = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREGS*WIDTH-1:0] reg_bank,
  input  logic [4:0]             reg_num,
  input  logic [1:0]             src_sel,
  input  logic [WIDTH-1:0]       reg_r,
  input  logic [IMM_W-1:0]       imm,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SEL_COUNT_W-1:0] sel_count
);

  localparam int unsigned DEPTH = BUF_DEPTH;
  localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [WIDTH-1:0] bank [NREGS];
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] op_data;
  logic             op_err;

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic             mem_err  [DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  // Unflatten the register bank for indexed reads.
  for (genvar i = 0; i < int'(NREGS); i++) begin : g_bank
    assign bank[i] = reg_bank[i*WIDTH +: WIDTH];
  end

  sign_extend #(
    .IN_W  (IMM_W),
    .OUT_W (WIDTH)
  ) u_sign_extend (
    .din      (imm),
    .zero_ext (src_sel == SRC_IMM_Z),
    .dout     (imm_ext)
  );

  // Operand mux; an out-of-range bank index yields zero data and an error flag.
  always_comb begin
    op_data = '0;
    op_err  = 1'b0;
    case (src_sel_e'(src_sel))
      SRC_BANK: begin
        if ({1'b0, reg_num} < 6'(NREGS)) begin
          op_data = bank[reg_num[IDX_W-1:0]];
        end else begin
          op_err = 1'b1;
        end
      end
      SRC_R:     op_data = reg_r;
      SRC_IMM_S: op_data = imm_ext;
      SRC_IMM_Z: op_data = imm_ext;
      default:   op_data = '0;
    endcase
  end

  // Ready depends only on occupancy, and never while reset is held.
  assign in_ready  = ~reset & (count < 2'(DEPTH));
  assign out_valid = (count != 2'd0);
  assign out_data  = mem_data[rd_ptr];
  assign out_err   = mem_err[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // FIFO storage, pointers, occupancy and saturating accept counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data[i] <= '0;
        mem_err[i]  <= 1'b0;
      end
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      sel_count <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= op_data;
        mem_err[wr_ptr]  <= op_err;
        wr_ptr           <= wr_ptr + 1'b1;
        if (sel_count != '1) begin
          sel_count <= sel_count + SEL_COUNT_W'(1);
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule : operand_select

// File: tb/tb_operand_select.sv
// Directed self-checking bench for operand_select.
module tb_operand_select;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREGS = 8;
  localparam int unsigned IMM_W = 10;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [NREGS*WIDTH-1:0] reg_bank;
  logic [4:0]             reg_num;
  logic [1:0]             src_sel;
  logic [WIDTH-1:0]       reg_r;
  logic [IMM_W-1:0]       imm;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_err;
  logic                   out_valid;
  logic                   out_ready;
  logic [15:0]            sel_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  operand_select #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .IMM_W (IMM_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .reg_bank  (reg_bank),
    .reg_num   (reg_num),
    .src_sel   (src_sel),
    .reg_r     (reg_r),
    .imm       (imm),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_count (sel_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single request with an idle buffer: visible one edge later, then drained.
  task automatic one_shot(input string tag, input logic [1:0] sel, input logic [4:0] num,
                          input logic [15:0] r, input logic [9:0] im,
                          input logic [15:0] exp_data, input logic exp_err);
    src_sel  = sel;
    reg_num  = num;
    reg_r    = r;
    imm      = im;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_cnt++;
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_err"}, out_err, exp_err);
    tick();
    check({tag, "_drained"}, out_valid, 1'b0);
    check({tag, "_count"}, sel_count, exp_cnt);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    src_sel   = 2'd0;
    reg_num   = 5'd0;
    reg_r     = '0;
    imm       = '0;
    for (int i = 0; i < int'(NREGS); i++) reg_bank[i*WIDTH +: WIDTH] = 16'(i);

    // Reset state
    tick();
    tick();
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 16'h0);
    check("rst_err", out_err, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    check("rst_cnt", sel_count, 16'h0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1'b1);

    // Source selection
    one_shot("bank3",   2'd0, 5'd3,  16'h0,  10'h0,   16'h0003, 1'b0);
    one_shot("reg_r",   2'd1, 5'd0,  16'h9,  10'h0,   16'h0009, 1'b0);
    one_shot("imm_s1",  2'd2, 5'd0,  16'h0,  10'h3FF, 16'hFFFF, 1'b0);
    one_shot("imm_z1",  2'd3, 5'd0,  16'h0,  10'h3FF, 16'h03FF, 1'b0);
    one_shot("imm_s2",  2'd2, 5'd0,  16'h0,  10'h200, 16'hFE00, 1'b0);
    one_shot("imm_s3",  2'd2, 5'd0,  16'h0,  10'h1FF, 16'h01FF, 1'b0);
    one_shot("bank7",   2'd0, 5'd7,  16'h0,  10'h0,   16'h0007, 1'b0);
    one_shot("bank8",   2'd0, 5'd8,  16'h0,  10'h0,   16'h0000, 1'b1);
    one_shot("bank12",  2'd0, 5'd12, 16'h0,  10'h0,   16'h0000, 1'b1);

    // Unknown select while idle leaves state alone
    src_sel = 2'bxx;
    reg_num = 5'bxxxxx;
    tick();
    check("x_idle_valid", out_valid, 1'b0);
    check("x_idle_cnt", sel_count, exp_cnt);

    // Backpressure: two accepted, third stalls, order kept
    out_ready = 1'b0;
    src_sel   = 2'd1;
    reg_r     = 16'd1;
    in_valid  = 1'b1;
    tick();
    check("bp1_ready", in_ready, 1'b1);
    check("bp1_data", out_data, 16'd1);
    reg_r = 16'd2;
    tick();
    check("bp2_ready", in_ready, 1'b0);
    check("bp2_data", out_data, 16'd1);
    reg_r = 16'd4;
    tick();
    exp_cnt += 2;
    check("bp3_ready", in_ready, 1'b0);
    check("bp3_hold", out_data, 16'd1);
    check("bp3_cnt", sel_count, exp_cnt);
    out_ready = 1'b1;
    tick();
    check("bp_pop1", out_data, 16'd2);
    check("bp_ready_back", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    exp_cnt++;
    check("bp_pop2_valid", out_valid, 1'b1);
    check("bp_pop2", out_data, 16'd4);
    check("bp_cnt", sel_count, exp_cnt);
    tick();
    check("bp_empty", out_valid, 1'b0);

    // Steady stream: one result per cycle, occupancy stays at one
    src_sel  = 2'd1;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      reg_r = 16'(100 + k);
      tick();
      check("stream_data", out_data, 16'(100 + k));
      check("stream_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    exp_cnt += 8;
    check("stream_cnt", sel_count, exp_cnt);
    tick();
    check("stream_empty", out_valid, 1'b0);

    // Reset while full discards entries and ignores requests
    out_ready = 1'b0;
    in_valid  = 1'b1;
    reg_r     = 16'h55;
    tick();
    tick();
    check("full_ready", in_ready, 1'b0);
    reset = 1'b1;
    tick();
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_cnt", sel_count, 16'h0);
    check("midrst_ready", in_ready, 1'b0);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("postrst_valid", out_valid, 1'b0);
    check("postrst_cnt", sel_count, 16'h0);

    // Saturation of the accept counter
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 65540; i++) begin
      tick();
      if (i == 65534) check("sat_fffe", sel_count, 16'hFFFE);
      if (i == 65535) check("sat_ffff", sel_count, 16'hFFFF);
    end
    in_valid = 1'b0;
    check("sat_hold", sel_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_operand_select

// File: doc/operand_select.md
OPERAND_SELECT -- requirements
Module: operand_select

Interface
REQ-001 Parameter WIDTH, default 16, data width of all operands and output.
REQ-002 Parameter NREGS, default 8, number of bank registers (power of 2, 2..32).
REQ-003 Parameter IMM_W, default 10, width of raw immediate (IMM_W < WIDTH).
REQ-004 Parameter DEPTH, fixed 2, output buffer entries.
REQ-005 clock  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 reg_bank  in  NREGS*WIDTH  flattened registers; reg i at bits [i*WIDTH +: WIDTH].
REQ-008 reg_num  in  5  register index.
REQ-009 src_sel  in  2  source: 0 bank[reg_num], 1 reg_r, 2 imm sign-extended, 3 imm zero-extended.
REQ-010 reg_r  in  WIDTH  R-type operand.
REQ-011 imm  in  IMM_W  raw immediate.
REQ-012 in_valid  in  1  request present.
REQ-013 in_ready  out  1  request accepted when in_valid and in_ready both high.
REQ-014 out_data  out  WIDTH  selected operand at buffer head.
REQ-015 out_err  out  1  head entry had illegal index.
REQ-016 out_valid  out  1  head entry present.
REQ-017 out_ready  in  1  consumer takes head when out_valid and out_ready both high.
REQ-018 sel_count  out  16  number of accepted requests, saturating.

Function
REQ-019 Operand SHALL be computed combinationally from inputs sampled in the accept cycle and written to the buffer at that edge.
REQ-020 Source 2 SHALL replicate imm[IMM_W-1] into bits WIDTH-1..IMM_W; source 3 SHALL fill those bits with 0.
REQ-021 For src_sel 0 with reg_num >= NREGS, entry data SHALL be 0 and err SHALL be 1; all other entries err 0.
REQ-022 Buffer SHALL be a 2-entry FIFO (count 0..2); in_ready SHALL equal (count < 2), independent of out_ready.
REQ-023 Latency SHALL be 1 cycle: request accepted at edge N is visible on out_* after edge N when buffer was empty.
REQ-024 out_valid SHALL equal (count != 0); out_data/out_err SHALL present the oldest entry.
REQ-025 Simultaneous accept and pop SHALL leave count unchanged and preserve order.
REQ-026 With count 2, in_ready SHALL be 0; a pop that cycle frees one entry, in_ready rises the following cycle.
REQ-027 Head outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 Write and read pointers SHALL wrap modulo 2.
REQ-029 sel_count SHALL increment by 1 per accepted request and hold at 16'hFFFF.
REQ-030 X on src_sel/reg_num while in_valid=0 SHALL not affect state.

Reset
REQ-031 While reset=1 at an edge: count=0, pointers=0, sel_count=0; out_valid=0, out_data=0, out_err=0, in_ready=0.
REQ-032 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-033 Reset mid-operation SHALL discard buffered entries; requests presented during reset are not accepted.

Structure
REQ-034 Source-select codes (SRC_BANK=0, SRC_R=1, SRC_IMM_S=2, SRC_IMM_Z=3) SHALL reside in shared package operand_pkg.
REQ-035 Immediate extension SHALL be a sub-module sign_extend (params IN_W, OUT_W; input zero_ext selects zero-extension).
REQ-036 Buffer and counter SHALL be in operand_select itself; no other sub-modules.

Verification
REQ-037 Defaults, reg i = i, src_sel 0, reg_num 3, out_ready 1 -> out_data 3, out_err 0 one cycle later.
REQ-038 src_sel 1, reg_r 9 -> out_data 9; src_sel 2, imm 10'b1111111111 -> 16'hFFFF; src_sel 3 same imm -> 16'h03FF.
REQ-039 src_sel 0, reg_num 12 -> out_data 0, out_err 1; sel_count increments.
REQ-040 out_ready 0, three back-to-back requests (values 1,2,4) -> first two accepted, in_ready 0; release out_ready -> outputs 1,2, then 4 accepted and output in order.
REQ-041 Steady stream with out_ready 1 -> one result per cycle, count stays 1, ordering preserved.
REQ-042 Reset asserted with count 2 -> next cycle out_valid 0, sel_count 0; 65540 accepts -> sel_count 16'hFFFF.
